idct_block_serializer: RTL

Consumes the 2048-bit spatial-domain blocks produced by the IDCT stage, one 64-sample 8x8 block per beat. Level-shifts each sample by +128, clamps it to 8 bits, and streams the pixels out one per cycle with valid/ready and an end-of-block flag. Holds two blocks in ping-pong buffers, so one block can be accepted while the previous one drains. Sits between the IDCT stage and the colour-conversion/pixel-writer stages of the decoder.

---
 rtl/idct_pkg.sv | 30 +++
 rtl/pixel_clamp.sv | 30 +++
 rtl/idct_block_serializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT datapath and its neighbours.
//   COEF_W      : width of one signed spatial-domain sample
//   PIX_W       : width of an output pixel
//   N           : block edge length (8x8 blocks)
//   BLOCK_W     : width of one packed block (N*N samples)
//   LEVEL_SHIFT : offset added to a sample before saturation
//   fill_e      : occupancy of the two-slot block buffer
//   sample_offset() : bit offset of sample (row, col) in a packed block
package idct_pkg;

    localparam int COEF_W      = 32;
    localparam int PIX_W       = 8;
    localparam int N           = 8;
    localparam int BLOCK_W     = COEF_W * N * N;
    localparam int LEVEL_SHIFT = 128;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2
    } fill_e;

    // Rows are packed N samples wide; the row index selects the outer stride.
    function automatic int sample_offset(input logic [2:0] row,
                                         input logic [2:0] col,
                                         input int         coef_w);
        return (int'(row) * N + int'(col)) * coef_w;
    endfunction

endpackage

// File: rtl/pixel_clamp.sv
// Level shift plus saturation of one signed sample to an unsigned pixel.
//   coef_i : signed COEF_W sample
//   pix_o  : clamp(coef_i + LEVEL_SHIFT) into 0 .. 2**PIX_W-1
module pixel_clamp #(
    parameter int COEF_W      = 32,
    parameter int PIX_W       = 8,
    parameter int LEVEL_SHIFT = 128
) (
    input  logic signed [COEF_W-1:0] coef_i,
    output logic        [PIX_W-1:0]  pix_o
);

    localparam logic signed [COEF_W:0] SHIFT_S = (COEF_W+1)'(LEVEL_SHIFT);
    localparam logic signed [COEF_W:0] MAX_S   = (COEF_W+1)'((1 << PIX_W) - 1);

    // One extra bit so the shift of a large positive sample cannot wrap.
    logic signed [COEF_W:0] sum;

    assign sum = $signed({coef_i[COEF_W-1], coef_i}) + SHIFT_S;

    always_comb begin
        pix_o = sum[PIX_W-1:0];
        if (sum[COEF_W]) begin
            pix_o = '0;
        end else if (sum > MAX_S) begin
            pix_o = '1;
        end
    end

endmodule

// File: rtl/idct_block_serializer.sv
// Accepts one 8x8 spatial-domain block per beat into a two-slot ping-pong
// buffer and streams it out one clamped pixel per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   s_data    : packed block, row r at [256r +: 256], column c at [32c +: 32]
//   s_valid   : block offered        s_ready : a buffer slot is free
//   m_data    : clamped pixel        m_valid : pixel present
//   m_ready   : pixel taken          m_last  : pixel 63 of a block
//   overflow  : sticky, a block was offered while no slot was free
module idct_block_serializer #(
    parameter int COEF_W      = idct_pkg::COEF_W,
    parameter int PIX_W       = idct_pkg::PIX_W,
    parameter int LEVEL_SHIFT = idct_pkg::LEVEL_SHIFT,
    parameter int TRANSPOSE   = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [COEF_W*idct_pkg::N*idct_pkg::N-1:0]     s_data,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    output logic [PIX_W-1:0]                              m_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_last,
    output logic                                          overflow
);

    import idct_pkg::*;

    localparam int BUF_W = COEF_W * N * N;
    localparam int OFF_W = $clog2(BUF_W);

    logic [BUF_W-1:0] blk_mem [2];

    fill_e      fill_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [5:0] idx_q;
    logic       overflow_q;

    logic                     accept;
    logic                     pix_fire;
    logic                     block_done;
    logic [2:0]               row;
    logic [2:0]               col;
    logic [OFF_W-1:0]         sample_off;
    logic signed [COEF_W-1:0] sample;
    logic [PIX_W-1:0]         clamped;

    assign s_ready    = !rst && (fill_q != FILL_TWO);
    assign accept     = s_valid && s_ready;
    assign m_valid    = (fill_q != FILL_EMPTY);
    assign pix_fire   = m_valid && m_ready;
    assign block_done = pix_fire && (idx_q == 6'd63);
    assign m_last     = m_valid && (idx_q == 6'd63);
    assign overflow   = overflow_q;

    // Scan order: the 6-bit index splits into row/column, swapped for
    // column-major output.
    generate
        if (TRANSPOSE != 0) begin : g_col_major
            assign row = idx_q[2:0];
            assign col = idx_q[5:3];
        end else begin : g_row_major
            assign row = idx_q[5:3];
            assign col = idx_q[2:0];
        end
    endgenerate

    assign sample_off = OFF_W'(sample_offset(row, col, COEF_W));
    assign sample     = blk_mem[rd_ptr_q][sample_off +: COEF_W];

    pixel_clamp #(
        .COEF_W      (COEF_W),
        .PIX_W       (PIX_W),
        .LEVEL_SHIFT (LEVEL_SHIFT)
    ) u_clamp (
        .coef_i (sample),
        .pix_o  (clamped)
    );

    // Slots are uninitialised after reset, so gate the pixel when empty.
    assign m_data = m_valid ? clamped : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            blk_mem[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q     <= FILL_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= 6'd0;
            overflow_q <= 1'b0;
        end else begin
            // Simultaneous accept and block completion keep the occupancy.
            unique case (fill_q)
                FILL_EMPTY: if (accept) fill_q <= FILL_ONE;
                FILL_ONE: begin
                    if (accept && !block_done) begin
                        fill_q <= FILL_TWO;
                    end else if (block_done && !accept) begin
                        fill_q <= FILL_EMPTY;
                    end
                end
                FILL_TWO:   if (block_done) fill_q <= FILL_ONE;
                default:    fill_q <= FILL_EMPTY;
            endcase

            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            // idx wraps 63 -> 0 naturally at block end.
            if (pix_fire) begin
                idx_q <= idx_q + 6'd1;
            end
            if (block_done) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (s_valid && !s_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
